// File: rtl/tm1638_pkg.sv
// Shared definitions for the TM1638 frame driver.
// Command bytes, FSM states and the hex-to-segment table.
package tm1638_pkg;

    localparam logic [7:0] CMD_DATA_AUTO = 8'h40;
    localparam logic [7:0] CMD_ADDR_BASE = 8'hC0;
    localparam logic [7:0] CMD_DISP_CTRL = 8'h80;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        BIT_LO,
        BIT_HI,
        HOLD,
        GAP,
        DONE
    } state_e;

    // Segment pattern gfedcba for one hex value.
    function automatic logic [6:0] seg_rom(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0:    s = 7'h3F;
            4'h1:    s = 7'h06;
            4'h2:    s = 7'h5B;
            4'h3:    s = 7'h4F;
            4'h4:    s = 7'h66;
            4'h5:    s = 7'h6D;
            4'h6:    s = 7'h7D;
            4'h7:    s = 7'h07;
            4'h8:    s = 7'h7F;
            4'h9:    s = 7'h6F;
            4'hA:    s = 7'h77;
            4'hB:    s = 7'h7C;
            4'hC:    s = 7'h39;
            4'hD:    s = 7'h5E;
            4'hE:    s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/tm1638_frame_driver_hex_to_7seg.sv
// One digit encoder: hex nibble plus decimal point to a segment byte.
// The decimal point rides in bit 7 above the gfedcba pattern.
module hex_to_7seg
    import tm1638_pkg::*;
(
    input  logic [3:0] value,
    input  logic       dp,
    output logic [7:0] seg
);

    assign seg = {dp, seg_rom(value)};

endmodule

// File: rtl/tm1638_frame_driver.sv
// TM1638 frame driver: snapshots digits, dp and LEDs, then sends the
// data-mode, addressed-burst and display-control segments on stb/clk/dio.
module tm1638_frame_driver
    import tm1638_pkg::*;
#(
    parameter int NUM_DIGITS   = 8,
    parameter int CLK_DIV      = 25,
    parameter int AUTO_REFRESH = 0,
    parameter int REFRESH_GAP  = 50000
) (
    input  logic                    _50MHz_CLK,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic [NUM_DIGITS-1:0]   leds,
    input  logic [2:0]              bright,
    input  logic                    disp_on,
    output logic                    busy,
    output logic                    done,
    output logic                    stb,
    output logic                    clk,
    output logic                    dio
);

    localparam int HW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int NB = 2 * NUM_DIGITS + 1;
    localparam int BW = $clog2(NB + 1);
    localparam int GW = $clog2(REFRESH_GAP + 1);

    localparam logic [HW-1:0] HALF_END = HW'(CLK_DIV - 1);
    localparam logic [BW-1:0] LAST_S2  = BW'(NB - 1);
    localparam logic [GW-1:0] GAP_END  = GW'(REFRESH_GAP - 1);
    localparam logic          AUTO_EN  = (AUTO_REFRESH != 0);

    state_e                  state_q, state_d;
    logic [HW-1:0]           half_q, half_d;
    logic [2:0]              bit_q, bit_d;
    logic [BW-1:0]           byte_q, byte_d;
    logic [1:0]              seg_q, seg_d;
    logic [GW-1:0]           gap_q, gap_d;
    logic                    armed_q, armed_d;
    logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
    logic [NUM_DIGITS-1:0]   dp_q, dp_d;
    logic [NUM_DIGITS-1:0]   leds_q, leds_d;
    logic [2:0]              bright_q, bright_d;
    logic                    disp_on_q, disp_on_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    stb_q, stb_d;
    logic                    clk_q, clk_d;
    logic                    dio_q, dio_d;

    logic [7:0]    seg_byte [NUM_DIGITS];
    logic [BW-1:0] tx_idx;
    logic [BW-1:0] data_idx;
    logic [7:0]    cur_byte;
    logic [2:0]    bit_nxt;
    logic [HW-1:0] half_nxt;
    logic          half_end;
    logic          last_byte;
    logic          auto_go;

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dig
        hex_to_7seg u_hex (
            .value (digits_q[4*i +: 4]),
            .dp    (dp_q[i]),
            .seg   (seg_byte[i])
        );
    end

    // After bit 7 the next bit to present belongs to the following byte.
    always_comb begin
        tx_idx   = (bit_q == 3'd7) ? byte_q + BW'(1) : byte_q;
        data_idx = tx_idx - BW'(1);
        cur_byte = CMD_DATA_AUTO;
        case (seg_q)
            2'd0: cur_byte = CMD_DATA_AUTO;
            2'd1: begin
                if (tx_idx == '0) begin
                    cur_byte = CMD_ADDR_BASE;
                end else begin
                    for (int i = 0; i < NUM_DIGITS; i++) begin
                        if (data_idx[BW-1:1] == (BW-1)'(i)) begin
                            cur_byte = data_idx[0] ? {7'd0, leds_q[i]}
                                                   : seg_byte[i];
                        end
                    end
                end
            end
            default: cur_byte = CMD_DISP_CTRL
                              | {4'd0, disp_on_q, bright_q};
        endcase
    end

    assign bit_nxt   = bit_q + 3'd1;
    assign half_end  = (half_q == HALF_END);
    assign half_nxt  = half_end ? '0 : half_q + HW'(1);
    assign last_byte = (seg_q == 2'd1) ? (byte_q == LAST_S2) : 1'b1;
    assign auto_go   = AUTO_EN && armed_q && (gap_q >= GAP_END);

    always_comb begin
        state_d   = state_q;
        half_d    = half_q;
        bit_d     = bit_q;
        byte_d    = byte_q;
        seg_d     = seg_q;
        gap_d     = gap_q;
        armed_d   = armed_q;
        digits_d  = digits_q;
        dp_d      = dp_q;
        leds_d    = leds_q;
        bright_d  = bright_q;
        disp_on_d = disp_on_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        stb_d     = stb_q;
        clk_d     = clk_q;
        dio_d     = dio_q;
        case (state_q)
            IDLE: begin
                if (start || auto_go) begin
                    digits_d  = digits;
                    dp_d      = dp;
                    leds_d    = leds;
                    bright_d  = bright;
                    disp_on_d = disp_on;
                    busy_d    = 1'b1;
                    stb_d     = 1'b0;
                    half_d    = '0;
                    bit_d     = '0;
                    byte_d    = '0;
                    seg_d     = '0;
                    gap_d     = '0;
                    state_d   = SETUP;
                end else if (armed_q && gap_q < GAP_END) begin
                    gap_d = gap_q + GW'(1);
                end
            end
            SETUP: begin
                half_d = half_nxt;
                if (half_end) begin
                    clk_d   = 1'b0;
                    dio_d   = cur_byte[bit_q];
                    state_d = BIT_LO;
                end
            end
            BIT_LO: begin
                half_d = half_nxt;
                if (half_end) begin
                    clk_d   = 1'b1;
                    state_d = BIT_HI;
                end
            end
            BIT_HI: begin
                half_d = half_nxt;
                if (half_end) begin
                    if (bit_q == 3'd7 && last_byte) begin
                        state_d = HOLD;
                    end else begin
                        clk_d   = 1'b0;
                        dio_d   = cur_byte[bit_nxt];
                        bit_d   = bit_nxt;
                        state_d = BIT_LO;
                        if (bit_q == 3'd7) begin
                            byte_d = byte_q + BW'(1);
                        end
                    end
                end
            end
            HOLD: begin
                half_d = half_nxt;
                if (half_end) begin
                    stb_d   = 1'b1;
                    dio_d   = 1'b1;
                    state_d = GAP;
                end
            end
            GAP: begin
                half_d = half_nxt;
                if (half_end) begin
                    if (seg_q == 2'd2) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = DONE;
                    end else begin
                        seg_d   = seg_q + 2'd1;
                        byte_d  = '0;
                        bit_d   = '0;
                        stb_d   = 1'b0;
                        state_d = SETUP;
                    end
                end
            end
            DONE: begin
                armed_d = AUTO_EN;
                gap_d   = AUTO_EN ? GW'(1) : '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge _50MHz_CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            half_q    <= '0;
            bit_q     <= '0;
            byte_q    <= '0;
            seg_q     <= '0;
            gap_q     <= '0;
            armed_q   <= 1'b0;
            digits_q  <= '0;
            dp_q      <= '0;
            leds_q    <= '0;
            bright_q  <= '0;
            disp_on_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            stb_q     <= 1'b1;
            clk_q     <= 1'b1;
            dio_q     <= 1'b1;
        end else begin
            state_q   <= state_d;
            half_q    <= half_d;
            bit_q     <= bit_d;
            byte_q    <= byte_d;
            seg_q     <= seg_d;
            gap_q     <= gap_d;
            armed_q   <= armed_d;
            digits_q  <= digits_d;
            dp_q      <= dp_d;
            leds_q    <= leds_d;
            bright_q  <= bright_d;
            disp_on_q <= disp_on_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            stb_q     <= stb_d;
            clk_q     <= clk_d;
            dio_q     <= dio_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign stb  = stb_q;
    assign clk  = clk_q;
    assign dio  = dio_q;

endmodule
